pipe_sched: RTL and testbench

Pipeline hazard and resource scheduler for the five-stage MIPS core. It drives the decode stage's `stall_87` and `branch_fw_a_87`/`branch_fw_b_87` inputs. It serialises access to the single shared multi-cycle multiply/divide unit. It sequences the drain-and-halt shutdown when the decode stage raises its halt flag.

---
 rtl/pipe_sched_pkg.sv | 45 ++++
 rtl/pipe_sched_hazard_cmp.sv | 47 ++++
 rtl/pipe_sched.sv | 148 ++++++++++++++
 tb/tb_pipe_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_sched_pkg.sv
// Shared decode constants, scheduler state encodings and instruction
// classification helpers for the five-stage MIPS core.
package pipe_sched_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] OPCODE_BEQ   = 6'h04;
    localparam logic [5:0] OPCODE_BNE   = 6'h05;
    localparam logic [5:0] OPCODE_MUL   = 6'h1C;
    localparam logic [5:0] OPCODE_SW    = 6'h2B;

    localparam logic [5:0] FUNC_JR    = 6'h08;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    localparam int MD_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        PS_RUN     = 2'd0,
        PS_MD_BUSY = 2'd1,
        PS_DRAIN   = 2'd2,
        PS_HALTED  = 2'd3
    } ps_state_e;

    function automatic logic is_div_op(input logic [5:0] op, input logic [5:0] fn);
        return (op == OPCODE_RTYPE) && ((fn == FUNC_DIV) || (fn == FUNC_DIVU));
    endfunction

    function automatic logic is_md_op(input logic [5:0] op, input logic [5:0] fn);
        return ((op == OPCODE_RTYPE) && ((fn == FUNC_MULT) || (fn == FUNC_MULTU)))
            || is_div_op(op, fn) || (op == OPCODE_MUL);
    endfunction

    function automatic logic is_br_op(input logic [5:0] op, input logic [5:0] fn);
        return (op == OPCODE_BEQ) || (op == OPCODE_BNE)
            || ((op == OPCODE_RTYPE) && (fn == FUNC_JR));
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OPCODE_RTYPE) || (op == OPCODE_BEQ) || (op == OPCODE_BNE)
            || (op == OPCODE_SW) || (op == OPCODE_MUL);
    endfunction

endpackage

// File: rtl/pipe_sched_hazard_cmp.sv
// Combinational register-dependency comparators: load-use and branch
// hazard terms plus the raw EX/MEM branch-operand forward selects.
module hazard_cmp
    import pipe_sched_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [5:0] id_op_i,
    input  logic [5:0] id_fn_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic [4:0] ex_dst_i,
    input  logic       ex_reg_write_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] mem_dst_i,
    input  logic       mem_reg_write_i,
    input  logic       mem_mem_read_i,
    output logic       lu_o,
    output logic       bx_o,
    output logic       bm_o,
    output logic       fw_a_o,
    output logic       fw_b_o
);

    logic br_s;
    logic rt_used_s;
    logic ex_match_s;
    logic mem_match_s;
    logic mem_alu_s;

    // Dependency matches; register 0 never creates a hazard or forward.
    always_comb begin
        br_s        = is_br_op(id_op_i, id_fn_i);
        rt_used_s   = uses_rt(id_op_i);
        ex_match_s  = (ex_dst_i != 5'd0) &&
                      ((ex_dst_i == id_rs_i) || (rt_used_s && (ex_dst_i == id_rt_i)));
        mem_match_s = (mem_dst_i != 5'd0) &&
                      ((mem_dst_i == id_rs_i) || (rt_used_s && (mem_dst_i == id_rt_i)));
        mem_alu_s   = mem_reg_write_i && !mem_mem_read_i && (mem_dst_i != 5'd0);

        lu_o   = id_valid_i && ex_mem_read_i && ex_match_s;
        bx_o   = id_valid_i && br_s && ex_reg_write_i && ex_match_s;
        bm_o   = id_valid_i && br_s && mem_mem_read_i && mem_match_s;
        fw_a_o = br_s && mem_alu_s && (mem_dst_i == id_rs_i);
        fw_b_o = br_s && mem_alu_s && (mem_dst_i == id_rt_i);
    end

endmodule

// File: rtl/pipe_sched.sv
// Hazard/resource scheduler: decode stall and branch forwarding, shared
// multiply/divide unit arbitration and the drain-and-halt sequence.
module pipe_sched
    import pipe_sched_pkg::*;
#(
    parameter int MULT_CYCLES  = 4,
    parameter int DIV_CYCLES   = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk_87,
    input  logic       rst_n_87,
    input  logic       id_valid_87,
    input  logic [5:0] id_op_87,
    input  logic [5:0] id_fn_87,
    input  logic [4:0] id_rs_87,
    input  logic [4:0] id_rt_87,
    input  logic [4:0] ex_dst_87,
    input  logic       ex_reg_write_87,
    input  logic       ex_mem_read_87,
    input  logic [4:0] mem_dst_87,
    input  logic       mem_reg_write_87,
    input  logic       mem_mem_read_87,
    input  logic       halt_req_87,
    output logic       stall_87,
    output logic       branch_fw_a_87,
    output logic       branch_fw_b_87,
    output logic       md_busy_87,
    output logic       md_done_87,
    output logic       halted_87
);

    localparam logic [MD_CNT_WIDTH-1:0] MULT_LOAD  = MD_CNT_WIDTH'(MULT_CYCLES - 1);
    localparam logic [MD_CNT_WIDTH-1:0] DIV_LOAD   = MD_CNT_WIDTH'(DIV_CYCLES - 1);
    localparam logic [MD_CNT_WIDTH-1:0] DRAIN_LOAD = MD_CNT_WIDTH'(DRAIN_CYCLES - 1);
    localparam logic [MD_CNT_WIDTH-1:0] CNT_ZERO   = '0;

    ps_state_e                state_q, state_d;
    logic [MD_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                     halt_pend_q, halt_pend_d;

    logic lu_s, bx_s, bm_s, fw_a_raw_s, fw_b_raw_s;
    logic md_op_s, hz_stall_s;
    logic stall_s, fw_a_s, fw_b_s, md_busy_s, md_done_s, halted_s;

    hazard_cmp u_hazard_cmp (
        .id_valid_i      (id_valid_87),
        .id_op_i         (id_op_87),
        .id_fn_i         (id_fn_87),
        .id_rs_i         (id_rs_87),
        .id_rt_i         (id_rt_87),
        .ex_dst_i        (ex_dst_87),
        .ex_reg_write_i  (ex_reg_write_87),
        .ex_mem_read_i   (ex_mem_read_87),
        .mem_dst_i       (mem_dst_87),
        .mem_reg_write_i (mem_reg_write_87),
        .mem_mem_read_i  (mem_mem_read_87),
        .lu_o            (lu_s),
        .bx_o            (bx_s),
        .bm_o            (bm_s),
        .fw_a_o          (fw_a_raw_s),
        .fw_b_o          (fw_b_raw_s)
    );

    // Next-state and per-state outputs; halt outranks issuing a mult/div.
    always_comb begin
        md_op_s     = id_valid_87 && is_md_op(id_op_87, id_fn_87);
        hz_stall_s  = lu_s || bx_s || bm_s || (md_op_s && (state_q != PS_RUN));
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        stall_s     = 1'b1;
        md_busy_s   = 1'b0;
        md_done_s   = 1'b0;
        halted_s    = 1'b0;
        case (state_q)
            PS_RUN: begin
                stall_s     = hz_stall_s;
                halt_pend_d = 1'b0;
                if (halt_req_87) begin
                    state_d = PS_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else if (md_op_s && !hz_stall_s) begin
                    state_d = PS_MD_BUSY;
                    cnt_d   = is_div_op(id_op_87, id_fn_87) ? DIV_LOAD : MULT_LOAD;
                end else begin
                    state_d = PS_RUN;
                end
            end
            PS_MD_BUSY: begin
                stall_s   = hz_stall_s;
                md_busy_s = 1'b1;
                if (cnt_q == CNT_ZERO) begin
                    md_done_s   = 1'b1;
                    halt_pend_d = 1'b0;
                    if (halt_pend_q || halt_req_87) begin
                        state_d = PS_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        state_d = PS_RUN;
                    end
                end else begin
                    cnt_d       = cnt_q - {{(MD_CNT_WIDTH-1){1'b0}}, 1'b1};
                    halt_pend_d = halt_pend_q || halt_req_87;
                end
            end
            PS_DRAIN: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = PS_HALTED;
                end else begin
                    cnt_d = cnt_q - {{(MD_CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            PS_HALTED: begin
                halted_s = 1'b1;
            end
            default: begin
                state_d = PS_RUN;
                cnt_d   = CNT_ZERO;
            end
        endcase
        fw_a_s = fw_a_raw_s && !stall_s;
        fw_b_s = fw_b_raw_s && !stall_s;
    end

    // Scheduler state, shared occupancy/drain counter and sticky halt request.
    always_ff @(posedge clk_87 or negedge rst_n_87) begin
        if (!rst_n_87) begin
            state_q     <= PS_RUN;
            cnt_q       <= CNT_ZERO;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Decode sees zero-latency outputs, held low while reset is asserted.
    always_comb begin
        stall_87       = rst_n_87 && stall_s;
        branch_fw_a_87 = rst_n_87 && fw_a_s;
        branch_fw_b_87 = rst_n_87 && fw_b_s;
        md_busy_87     = rst_n_87 && md_busy_s;
        md_done_87     = rst_n_87 && md_done_s;
        halted_87      = rst_n_87 && halted_s;
    end

endmodule

// File: tb/tb_pipe_sched.sv
// Self-checking bench for pipe_sched: hazard vector table, hand-written
// multi-cycle sequences and randomized traffic against a timeline model.
module tb_pipe_sched;

    localparam int MULT_C  = 4;
    localparam int DIV_C   = 8;
    localparam int DRAIN_C = 3;

    logic       clk_87 = 1'b0;
    logic       rst_n_87;
    logic       id_valid_87;
    logic [5:0] id_op_87, id_fn_87;
    logic [4:0] id_rs_87, id_rt_87, ex_dst_87, mem_dst_87;
    logic       ex_reg_write_87, ex_mem_read_87, mem_reg_write_87, mem_mem_read_87;
    logic       halt_req_87;
    logic       stall_87, branch_fw_a_87, branch_fw_b_87, md_busy_87, md_done_87, halted_87;

    int checks = 0;
    int errors = 0;

    pipe_sched #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C), .DRAIN_CYCLES(DRAIN_C)) dut (
        .clk_87(clk_87), .rst_n_87(rst_n_87), .id_valid_87(id_valid_87),
        .id_op_87(id_op_87), .id_fn_87(id_fn_87), .id_rs_87(id_rs_87), .id_rt_87(id_rt_87),
        .ex_dst_87(ex_dst_87), .ex_reg_write_87(ex_reg_write_87), .ex_mem_read_87(ex_mem_read_87),
        .mem_dst_87(mem_dst_87), .mem_reg_write_87(mem_reg_write_87),
        .mem_mem_read_87(mem_mem_read_87), .halt_req_87(halt_req_87),
        .stall_87(stall_87), .branch_fw_a_87(branch_fw_a_87), .branch_fw_b_87(branch_fw_b_87),
        .md_busy_87(md_busy_87), .md_done_87(md_done_87), .halted_87(halted_87)
    );

    always #5 clk_87 = ~clk_87;

    typedef struct {
        string      name;
        logic       valid;
        logic [5:0] op, fn;
        logic [4:0] rs, rt, exd;
        logic       exrw, exmr;
        logic [4:0] memd;
        logic       memrw, memmr;
        logic       e_stall, e_fa, e_fb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic valid, input logic [5:0] op,
                                input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] exd, input logic exrw, input logic exmr,
                                input logic [4:0] memd, input logic memrw, input logic memmr,
                                input logic es, input logic efa, input logic efb);
        vec_t v;
        v.name = nm; v.valid = valid; v.op = op; v.fn = fn; v.rs = rs; v.rt = rt;
        v.exd = exd; v.exrw = exrw; v.exmr = exmr; v.memd = memd; v.memrw = memrw;
        v.memmr = memmr; v.e_stall = es; v.e_fa = efa; v.e_fb = efb;
        return v;
    endfunction

    task automatic set_in(input logic valid, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] exd,
                          input logic exrw, input logic exmr, input logic [4:0] memd,
                          input logic memrw, input logic memmr, input logic halt);
        id_valid_87 = valid; id_op_87 = op; id_fn_87 = fn; id_rs_87 = rs; id_rt_87 = rt;
        ex_dst_87 = exd; ex_reg_write_87 = exrw; ex_mem_read_87 = exmr;
        mem_dst_87 = memd; mem_reg_write_87 = memrw; mem_mem_read_87 = memmr;
        halt_req_87 = halt;
    endtask

    task automatic idle(input logic halt);
        set_in(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, halt);
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic es, input logic efa, input logic efb,
                           input logic eb, input logic ed, input logic eh);
        chk({nm, ".stall"},  stall_87,       es);
        chk({nm, ".fw_a"},   branch_fw_a_87, efa);
        chk({nm, ".fw_b"},   branch_fw_b_87, efb);
        chk({nm, ".busy"},   md_busy_87,     eb);
        chk({nm, ".done"},   md_done_87,     ed);
        chk({nm, ".halted"}, halted_87,      eh);
    endtask

    task automatic reset_dut();
        rst_n_87 = 1'b0;
        idle(1'b0);
        @(negedge clk_87);
        @(negedge clk_87);
        rst_n_87 = 1'b1;
    endtask

    // Reference model: the mult/div unit and the halt are tracked as cycle
    // windows on an absolute timeline rather than as a state machine.
    int m_cyc, m_busy_first, m_busy_last, m_drain_first, m_halt_first;
    bit m_pend;

    task automatic model_reset();
        m_cyc = 0; m_busy_first = -1; m_busy_last = -1;
        m_drain_first = 32'h7fff_ffff; m_halt_first = 32'h7fff_ffff; m_pend = 1'b0;
    endtask

    task automatic model_step();
        bit busy, drain, halted, run, br, urt, md, isdiv, lu, bx, bm, ms, st, fa, fb;
        busy   = (m_cyc >= m_busy_first) && (m_cyc <= m_busy_last);
        drain  = (m_cyc >= m_drain_first) && (m_cyc < m_halt_first);
        halted = (m_cyc >= m_halt_first);
        run    = !busy && !drain && !halted;
        br     = (id_op_87 == 6'h04) || (id_op_87 == 6'h05) || (id_op_87 == 6'h00 && id_fn_87 == 6'h08);
        urt    = (id_op_87 == 6'h00) || (id_op_87 == 6'h04) || (id_op_87 == 6'h05) ||
                 (id_op_87 == 6'h2B) || (id_op_87 == 6'h1C);
        isdiv  = (id_op_87 == 6'h00) && (id_fn_87 == 6'h1A || id_fn_87 == 6'h1B);
        md     = isdiv || (id_op_87 == 6'h1C) ||
                 ((id_op_87 == 6'h00) && (id_fn_87 == 6'h18 || id_fn_87 == 6'h19));
        lu = id_valid_87 && ex_mem_read_87 && ex_dst_87 != 0 &&
             (ex_dst_87 == id_rs_87 || (urt && ex_dst_87 == id_rt_87));
        bx = id_valid_87 && br && ex_reg_write_87 && ex_dst_87 != 0 &&
             (ex_dst_87 == id_rs_87 || (urt && ex_dst_87 == id_rt_87));
        bm = id_valid_87 && br && mem_mem_read_87 && mem_dst_87 != 0 &&
             (mem_dst_87 == id_rs_87 || (urt && mem_dst_87 == id_rt_87));
        ms = id_valid_87 && md && busy;
        st = (drain || halted) ? 1'b1 : (lu || bx || bm || ms);
        fa = !st && br && mem_reg_write_87 && !mem_mem_read_87 && mem_dst_87 != 0 && mem_dst_87 == id_rs_87;
        fb = !st && br && mem_reg_write_87 && !mem_mem_read_87 && mem_dst_87 != 0 && mem_dst_87 == id_rt_87;
        chk_all("rand", st, fa, fb, busy, busy && (m_cyc == m_busy_last), halted);
        if (run) begin
            if (halt_req_87) begin
                m_drain_first = m_cyc + 1;
                m_halt_first  = m_cyc + 1 + DRAIN_C;
            end else if (id_valid_87 && md && !st) begin
                m_busy_first = m_cyc + 1;
                m_busy_last  = m_cyc + (isdiv ? DIV_C : MULT_C);
            end
        end else if (busy) begin
            if (halt_req_87) m_pend = 1'b1;
            if (m_cyc == m_busy_last) begin
                if (m_pend) begin
                    m_drain_first = m_cyc + 1;
                    m_halt_first  = m_cyc + 1 + DRAIN_C;
                end
                m_pend = 1'b0;
            end
        end
        m_cyc++;
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [7];
        ops = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h2B, 6'h1C, 6'h08};
        return ops[$urandom_range(0, 6)];
    endfunction

    function automatic logic [5:0] pick_fn();
        logic [5:0] fns [6];
        fns = '{6'h20, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h08};
        return fns[$urandom_range(0, 5)];
    endfunction

    initial begin
        // Reset state, with a load-use hazard presented on the inputs.
        rst_n_87 = 1'b0;
        set_in(1'b1, 6'h04, 6'h00, 5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1);
        #12;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_dut();

        //          name          v     op     fn     rs  rt  exd  rw mr memd rw mr  st fa fb
        vecs.push_back(mk("lu_add",  1, 6'h00, 6'h20, 2,  4,  2,  1, 1, 0,  0, 0,  1, 0, 0));
        vecs.push_back(mk("lu_r0",   1, 6'h00, 6'h20, 0,  4,  0,  1, 1, 0,  0, 0,  0, 0, 0));
        vecs.push_back(mk("addi_rt", 1, 6'h08, 6'h00, 2,  3,  3,  1, 1, 0,  0, 0,  0, 0, 0));
        vecs.push_back(mk("lu_sw",   1, 6'h2B, 6'h00, 1,  5,  5,  1, 1, 0,  0, 0,  1, 0, 0));
        vecs.push_back(mk("bx_beq",  1, 6'h04, 6'h00, 5,  6,  5,  1, 0, 0,  0, 0,  1, 0, 0));
        vecs.push_back(mk("fw_a",    1, 6'h04, 6'h00, 5,  6,  0,  0, 0, 5,  1, 0,  0, 1, 0));
        vecs.push_back(mk("bm_bne",  1, 6'h05, 6'h00, 1,  6,  0,  0, 0, 6,  1, 1,  1, 0, 0));
        vecs.push_back(mk("fw_ab",   1, 6'h04, 6'h00, 7,  7,  0,  0, 0, 7,  1, 0,  0, 1, 1));
        vecs.push_back(mk("fw_r0",   1, 6'h04, 6'h00, 0,  0,  0,  1, 0, 0,  1, 0,  0, 0, 0));
        vecs.push_back(mk("nofw_add",1, 6'h00, 6'h20, 5,  6,  0,  0, 0, 5,  1, 0,  0, 0, 0));
        vecs.push_back(mk("fw_jr",   1, 6'h00, 6'h08, 9,  0,  0,  0, 0, 9,  1, 0,  0, 1, 0));
        vecs.push_back(mk("lu_inval",0, 6'h00, 6'h20, 2,  4,  2,  1, 1, 0,  0, 0,  0, 0, 0));
        vecs.push_back(mk("fw_kill", 1, 6'h04, 6'h00, 5,  6,  6,  1, 1, 5,  1, 0,  1, 0, 0));
        vecs.push_back(mk("alu_ex",  1, 6'h00, 6'h20, 2,  4,  2,  1, 0, 0,  0, 0,  0, 0, 0));
        foreach (vecs[i]) begin
            @(negedge clk_87);
            set_in(vecs[i].valid, vecs[i].op, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].exd,
                   vecs[i].exrw, vecs[i].exmr, vecs[i].memd, vecs[i].memrw, vecs[i].memmr, 1'b0);
            #1;
            chk_all(vecs[i].name, vecs[i].e_stall, vecs[i].e_fa, vecs[i].e_fb, 1'b0, 1'b0, 1'b0);
        end

        // Branch after ALU op: one stall, then forward from EX/MEM.
        @(negedge clk_87);
        set_in(1, 6'h04, 6'h00, 5, 6, 5, 1, 0, 0, 0, 0, 0);
        #1 chk_all("bralu_c1", 1, 0, 0, 0, 0, 0);
        @(negedge clk_87);
        set_in(1, 6'h04, 6'h00, 5, 6, 0, 0, 0, 5, 1, 0, 0);
        #1 chk_all("bralu_c2", 0, 1, 0, 0, 0, 0);

        // Branch after load: two stall cycles, never forwarded.
        @(negedge clk_87);
        set_in(1, 6'h05, 6'h00, 1, 6, 6, 1, 1, 0, 0, 0, 0);
        #1 chk_all("brld_c1", 1, 0, 0, 0, 0, 0);
        @(negedge clk_87);
        set_in(1, 6'h05, 6'h00, 1, 6, 0, 0, 0, 6, 1, 1, 0);
        #1 chk_all("brld_c2", 1, 0, 0, 0, 0, 0);
        @(negedge clk_87);
        set_in(1, 6'h05, 6'h00, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        #1 chk_all("brld_c3", 0, 0, 0, 0, 0, 0);

        // Back-to-back div then mult.
        reset_dut();
        @(negedge clk_87);
        set_in(1, 6'h00, 6'h1A, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        #1 chk_all("div_issue", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DIV_C; i++) begin
            @(negedge clk_87);
            set_in(1, 6'h00, 6'h18, 3, 4, 0, 0, 0, 0, 0, 0, 0);
            #1 chk_all("mult_wait", 1, 0, 0, 1, (i == DIV_C - 1), 0);
        end
        @(negedge clk_87);
        #1 chk_all("mult_issue", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MULT_C; i++) begin
            @(negedge clk_87);
            idle(1'b0);
            #1 chk_all("mult_busy", 0, 0, 0, 1, (i == MULT_C - 1), 0);
        end
        @(negedge clk_87);
        #1 chk_all("md_free", 0, 0, 0, 0, 0, 0);

        // Halt raised mid-divide is held until the unit frees.
        reset_dut();
        @(negedge clk_87);
        set_in(1, 6'h00, 6'h1B, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        #1 chk_all("div2_issue", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DIV_C; i++) begin
            @(negedge clk_87);
            idle(i == 2);
            #1 chk_all("hp_busy", 0, 0, 0, 1, (i == DIV_C - 1), 0);
        end
        for (int i = 0; i < DRAIN_C; i++) begin
            @(negedge clk_87);
            idle(1'b0);
            #1 chk_all("hp_drain", 1, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_87);
            #1 chk_all("hp_halted", 1, 0, 0, 0, 0, 1);
        end

        // Halt and div in the same cycle: halt wins, div never issues.
        reset_dut();
        @(negedge clk_87);
        set_in(1, 6'h00, 6'h1A, 1, 2, 0, 0, 0, 0, 0, 0, 1);
        #1 chk_all("hd_same", 0, 0, 0, 0, 0, 0);
        @(negedge clk_87);
        idle(1'b0);
        #1 chk_all("hd_drain", 1, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-drain, then normal operation.
        #1;
        set_in(1, 6'h00, 6'h20, 2, 4, 2, 1, 1, 0, 0, 0, 0);
        rst_n_87 = 1'b0;
        #1 chk_all("rst_drain", 0, 0, 0, 0, 0, 0);
        @(negedge clk_87);
        rst_n_87 = 1'b1;
        @(negedge clk_87);
        set_in(1, 6'h00, 6'h20, 2, 4, 0, 0, 0, 0, 0, 0, 0);
        #1 chk_all("post_rst", 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the timeline model.
        reset_dut();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk_87);
            set_in(($urandom_range(0, 3) != 0), pick_op(), pick_fn(),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 49) == 0));
            #1;
            model_step();
            if (m_cyc > m_halt_first + 3) begin
                reset_dut();
                model_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
